// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the memory bus trace capture unit.
//   trace_state_t  : capture FSM state, encoded as IDLE=0, ARMED=1, POST=2, DONE=3
//   trace_entry_t  : one captured access {wren, addr, data} at the default bus widths
//   STATE_*        : raw encodings for logic that compares the 2-bit state output
package trace_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_ARMED = 2'd1;
  localparam logic [1:0] STATE_POST  = 2'd2;
  localparam logic [1:0] STATE_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_ARMED = STATE_ARMED,
    ST_POST  = STATE_POST,
    ST_DONE  = STATE_DONE
  } trace_state_t;

  localparam int TRACE_ADDR_W = 16;
  localparam int TRACE_DATA_W = 8;

  // Default-width entry. Packages cannot take parameters, so the top level
  // declares the same layout at its own ADDR_W/DATA_W.
  typedef struct packed {
    logic                    wren;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port RAM, one write port and one registered read port.
// No reset on storage or read register so it maps onto block RAM.
//   clock   : system clock
//   wr_en   : write wr_data at wr_addr
//   rd_en   : load rd_data from rd_addr at the next edge
//   rd_data : registered read data
module trace_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 25,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mem_trace_capture.sv
// mem_trace_capture: records qualified CPU bus accesses into a circular buffer,
// stops POST_COUNT accesses after an address-match trigger, then lets the host
// drain the captured window oldest-first.
//   clock, reset          : system clock, async active-high reset
//   arm                   : restart capture with an empty buffer
//   bus_valid/addr/data/wren : bus sample
//   trig_addr/mask/write_only : trigger comparator setup
//   rd_en                 : pop oldest entry (DONE only)
//   rd_data, rd_valid     : popped entry {wren, addr, data}, one cycle after rd_en
//   state, triggered, count : status
//
// state | meaning
// IDLE  | no capture since reset
// ARMED | capturing, waiting for trigger
// POST  | trigger seen, capturing remaining post-trigger entries
// DONE  | capture frozen, buffer may be drained
import trace_pkg::*;

module mem_trace_capture #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 256,
  parameter int POST_COUNT = 128
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     bus_valid,
  input  logic [ADDR_W-1:0]        bus_addr,
  input  logic [DATA_W-1:0]        bus_data,
  input  logic                     bus_wren,
  input  logic [ADDR_W-1:0]        trig_addr,
  input  logic [ADDR_W-1:0]        trig_mask,
  input  logic                     trig_write_only,
  input  logic                     rd_en,
  output logic [ADDR_W+DATA_W:0]   rd_data,
  output logic                     rd_valid,
  output logic [1:0]               state,
  output logic                     triggered,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT  = AW'(POST_COUNT);

  typedef struct packed {
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  trace_state_t  state_q, state_d;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic [AW-1:0] post_cnt;
  logic          triggered_q;
  logic          rd_valid_q;

  logic          hit, capture, rd_go, load_post;
  logic [AW-1:0] rd_addr;
  entry_t        wr_entry;
  logic [EW-1:0] ram_q;

  assign hit = bus_valid
            && (((bus_addr ^ trig_addr) & trig_mask) == '0)
            && (!trig_write_only || bus_wren);

  // arm takes priority over both capture and reads in the same cycle
  assign capture = bus_valid && !arm && (state_q == ST_ARMED || state_q == ST_POST);
  assign rd_go   = rd_en && !arm && (state_q == ST_DONE) && (count_q != '0);

  // Oldest entry; when full the low bits of count are 0, so this is wr_ptr itself
  assign rd_addr = wr_ptr - count_q[AW-1:0];

  assign wr_entry.wren = bus_wren;
  assign wr_entry.addr = bus_addr;
  assign wr_entry.data = bus_data;

  always_comb begin
    state_d   = state_q;
    load_post = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (capture && hit) begin
          load_post = 1'b1;
          state_d   = (POST_COUNT == 0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (capture && post_cnt == AW'(1)) state_d = ST_DONE;
      end
      default: ;
    endcase
    if (arm) state_d = ST_ARMED;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr      <= '0;
      count_q     <= '0;
      post_cnt    <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_go;
      if (arm) begin
        wr_ptr      <= '0;
        count_q     <= '0;
        post_cnt    <= '0;
        triggered_q <= 1'b0;
      end else if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count_q != COUNT_FULL) count_q <= count_q + (AW+1)'(1);
        if (load_post) begin
          triggered_q <= 1'b1;
          post_cnt    <= POST_INIT;
        end else if (state_q == ST_POST) begin
          post_cnt <= post_cnt - AW'(1);
        end
      end else if (rd_go) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (capture),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_en   (rd_go),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // RAM read register has no reset; mask it so rd_data is 0 whenever not valid
  assign rd_data   = rd_valid_q ? ram_q : '0;
  assign rd_valid  = rd_valid_q;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign count     = count_q;

endmodule
